// File: rtl/ysyx_23060221_pkg.sv
// Shared definitions for the write-back stage: wbsel encodings, FSM state type,
// data width and a register-range helper.
package ysyx_23060221_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_CSR = 2'b11;

  typedef enum logic {
    IDLE,
    COMMIT
  } wbu_state_t;

  // True when a 5-bit register index exists in a file of nr_regs entries.
  function automatic logic reg_in_range(input logic [4:0] addr, input int unsigned nr_regs);
    return 32'(addr) < nr_regs;
  endfunction

endpackage

// File: rtl/ysyx_23060221_gpr.sv
// Architectural GPR file: one write port, two combinational read ports.
// x0 and indices >= NR_REGS read as zero and ignore writes.
// Optional macro WBU_RD_BYPASS_EN forwards the in-flight write data to the read ports.
module ysyx_23060221_gpr
  import ysyx_23060221_pkg::*;
#(
  parameter int unsigned NR_REGS = 32,
  parameter int unsigned XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wen,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  localparam int unsigned AW = (NR_REGS > 1) ? $clog2(NR_REGS) : 1;

  logic [XLEN-1:0] regs_q [NR_REGS];
  logic            wen_ok;

  assign wen_ok = wen && (waddr != 5'd0) && reg_in_range(waddr, NR_REGS);

  // Register array: cleared on reset, single write per cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NR_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wen_ok) begin
      regs_q[waddr[AW-1:0]] <= wdata;
    end
  end

  // Read ports with zero for x0 and out-of-range indices.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if ((raddr1 != 5'd0) && reg_in_range(raddr1, NR_REGS)) begin
      rdata1 = regs_q[raddr1[AW-1:0]];
    end
    if ((raddr2 != 5'd0) && reg_in_range(raddr2, NR_REGS)) begin
      rdata2 = regs_q[raddr2[AW-1:0]];
    end
`ifdef WBU_RD_BYPASS_EN
    // wen_ok already excludes x0 and out-of-range targets.
    if (wen_ok && (waddr == raddr1)) begin
      rdata1 = wdata;
    end
    if (wen_ok && (waddr == raddr2)) begin
      rdata2 = wdata;
    end
`endif
  end

endmodule

// File: rtl/ysyx_23060221_wbu.sv
// Write-back unit: accepts a completed instruction from the LSU, selects the
// write-back value, commits it to the GPR file on the IFU handshake and counts
// retired instructions. Optional macro WBU_RD_BYPASS_EN enables GPR read bypass.
module ysyx_23060221_wbu
  import ysyx_23060221_pkg::*;
#(
  parameter int unsigned NR_REGS = 32,
  parameter int unsigned XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            LSU_valid,
  output logic            WBU_ready,
  input  logic [XLEN-1:0] lsu_data,
  input  logic [XLEN-1:0] res,
  input  logic [XLEN-1:0] csr_rdata,
  input  logic [XLEN-1:0] pc,
  input  logic [4:0]      rd,
  input  logic            regwr,
  input  logic [1:0]      wbsel,
  output logic            WBU_valid,
  input  logic            IFU_ready,
  output logic [XLEN-1:0] commit_pc,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [63:0]     instret
);

  wbu_state_t      state_q, state_d;
  logic [XLEN-1:0] wb_q, pc_q, wb_d;
  logic [4:0]      rd_q;
  logic            regwr_q;
  logic [63:0]     instret_q;
  logic            accept, commit;

  // Handshake decode and write-back value select.
  always_comb begin
    WBU_ready = (state_q == IDLE);
    WBU_valid = (state_q == COMMIT);
    accept    = WBU_ready && LSU_valid;
    commit    = WBU_valid && IFU_ready;
    wb_d      = res;
    unique case (wbsel)
      WB_ALU: wb_d = res;
      WB_MEM: wb_d = lsu_data;
      WB_PC4: wb_d = pc + XLEN'(4);
      WB_CSR: wb_d = csr_rdata;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (accept) state_d = COMMIT;
      COMMIT: if (commit) state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Holding registers loaded on accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_q    <= '0;
      pc_q    <= '0;
      rd_q    <= '0;
      regwr_q <= 1'b0;
    end else if (accept) begin
      wb_q    <= wb_d;
      pc_q    <= pc;
      rd_q    <= rd;
      regwr_q <= regwr;
    end
  end

  // Retired-instruction counter, counts every commit handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instret_q <= '0;
    end else if (commit) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign commit_pc = pc_q;
  assign instret   = instret_q;

  ysyx_23060221_gpr #(
    .NR_REGS (NR_REGS),
    .XLEN    (XLEN)
  ) u_gpr (
    .clk    (clk),
    .rst    (rst),
    .wen    (commit && regwr_q),
    .waddr  (rd_q),
    .wdata  (wb_q),
    .raddr1 (rs1_addr),
    .raddr2 (rs2_addr),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data)
  );

endmodule

// File: tb/tb_ysyx_23060221_wbu.sv
// Directed bench for the write-back unit: an RV32I instance and an RV32E
// instance share stimulus; a queue holds expected commits.
module tb_ysyx_23060221_wbu;

  logic        clk = 1'b0;
  logic        rst;
  logic        LSU_valid, IFU_ready, regwr;
  logic [31:0] lsu_data, res, csr_rdata, pc;
  logic [4:0]  rd, rs1_addr, rs2_addr;
  logic [1:0]  wbsel;

  logic        WBU_ready, WBU_valid;
  logic [31:0] commit_pc, rs1_data, rs2_data;
  logic [63:0] instret;

  logic        WBU_ready_e, WBU_valid_e;
  logic [31:0] commit_pc_e, rs1_data_e, rs2_data_e;
  logic [63:0] instret_e;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] wb;
    logic [4:0]  rd;
    logic        regwr;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model   [32];
  logic [31:0] model_e [16];
  logic [63:0] instret_exp;

  always #5 clk = ~clk;

  ysyx_23060221_wbu #(.NR_REGS(32), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .LSU_valid(LSU_valid), .WBU_ready(WBU_ready),
    .lsu_data(lsu_data), .res(res), .csr_rdata(csr_rdata), .pc(pc), .rd(rd),
    .regwr(regwr), .wbsel(wbsel), .WBU_valid(WBU_valid), .IFU_ready(IFU_ready),
    .commit_pc(commit_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .instret(instret)
  );

  ysyx_23060221_wbu #(.NR_REGS(16), .XLEN(32)) dut_e (
    .clk(clk), .rst(rst), .LSU_valid(LSU_valid), .WBU_ready(WBU_ready_e),
    .lsu_data(lsu_data), .res(res), .csr_rdata(csr_rdata), .pc(pc), .rd(rd),
    .regwr(regwr), .wbsel(wbsel), .WBU_valid(WBU_valid_e), .IFU_ready(IFU_ready),
    .commit_pc(commit_pc_e), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data_e), .rs2_data(rs2_data_e), .instret(instret_e)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_wb(input logic [1:0] sel, input logic [31:0] r, l, c, p);
    case (sel)
      2'b00:   return r;
      2'b01:   return l;
      2'b10:   return p + 32'd4;
      default: return c;
    endcase
  endfunction

  function automatic logic [31:0] ref_e(input logic [4:0] a);
    if (a >= 5'd16) return 32'd0;
    return model_e[a[3:0]];
  endfunction

  task automatic read_check(input string tag, input logic [4:0] a);
    rs1_addr = a;
    #1;
    check(tag, rs1_data, model[a]);
    check({tag, "_e"}, rs1_data_e, ref_e(a));
  endtask

  task automatic clear_models();
    for (int i = 0; i < 32; i++) model[i] = '0;
    for (int i = 0; i < 16; i++) model_e[i] = '0;
    instret_exp = '0;
  endtask

  // One instruction: accept, optional IFU stall with ignored LSU pulses, commit.
  task automatic do_instr(input logic [1:0] sel, input logic [31:0] r, l, c, p,
                          input logic [4:0] d, input logic w, input int stall);
    exp_t        e;
    logic [31:0] byp_exp;
    @(negedge clk);
    wbsel = sel; res = r; lsu_data = l; csr_rdata = c; pc = p; rd = d; regwr = w;
    LSU_valid = 1'b1;
    IFU_ready = 1'b0;
    check("accept_ready", {63'd0, WBU_ready}, 64'd1);
    check("idle_valid", {63'd0, WBU_valid}, 64'd0);
    sb.push_back('{pc: p, wb: ref_wb(sel, r, l, c, p), rd: d, regwr: w});
    @(posedge clk); #1;
    LSU_valid = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_valid", {63'd0, WBU_valid}, 64'd1);
      check("stall_ready", {63'd0, WBU_ready}, 64'd0);
      check("stall_pc", {32'd0, commit_pc}, {32'd0, p});
      LSU_valid = 1'b1; rd = 5'd2; res = 32'h5555_5555; wbsel = 2'b00; regwr = 1'b1;
      @(posedge clk); #1;
      LSU_valid = 1'b0;
    end
    check("sb_nonempty", {63'd0, sb.size() != 0}, 64'd1);
    e = sb.pop_front();
    IFU_ready = 1'b1;
    rs2_addr  = e.rd;
    @(negedge clk);
    check("commit_valid", {63'd0, WBU_valid}, 64'd1);
    check("commit_pc", {32'd0, commit_pc}, {32'd0, e.pc});
    byp_exp = model[e.rd];
`ifdef WBU_RD_BYPASS_EN
    if (e.regwr && e.rd != 5'd0) byp_exp = e.wb;
`endif
    check("rs2_commit_cycle", {32'd0, rs2_data}, {32'd0, byp_exp});
    @(posedge clk); #1;
    IFU_ready = 1'b0;
    if (e.regwr && e.rd != 5'd0) model[e.rd] = e.wb;
    if (e.regwr && e.rd != 5'd0 && e.rd < 5'd16) model_e[e.rd[3:0]] = e.wb;
    instret_exp++;
    rs1_addr = e.rd;
    @(negedge clk);
    check("post_valid", {63'd0, WBU_valid}, 64'd0);
    check("post_ready", {63'd0, WBU_ready}, 64'd1);
    check("instret", instret, instret_exp);
    check("instret_e", instret_e, instret_exp);
    check("rs1_after", {32'd0, rs1_data}, {32'd0, model[e.rd]});
    check("rs2_after", {32'd0, rs2_data}, {32'd0, model[e.rd]});
    check("rs1_after_e", {32'd0, rs1_data_e}, {32'd0, ref_e(e.rd)});
  endtask

  initial begin
    rst = 1'b0;
    LSU_valid = 1'b0; IFU_ready = 1'b0; regwr = 1'b0;
    lsu_data = '0; res = '0; csr_rdata = '0; pc = '0;
    rd = '0; rs1_addr = 5'd5; rs2_addr = 5'd0; wbsel = 2'b00;
    clear_models();

    #12;
    check("rst_ready", {63'd0, WBU_ready}, 64'd1);
    check("rst_valid", {63'd0, WBU_valid}, 64'd0);
    check("rst_instret", instret, 64'd0);
    check("rst_commit_pc", {32'd0, commit_pc}, 64'd0);
    check("rst_x5", {32'd0, rs1_data}, 64'd0);
    rst = 1'b1;

    do_instr(2'b00, 32'h1234_5678, 32'h0, 32'h0, 32'h8000_0000, 5'd5, 1'b1, 0);
    do_instr(2'b01, 32'h0, 32'hFFFF_FF80, 32'h0, 32'h8000_0004, 5'd0, 1'b1, 0);
    do_instr(2'b01, 32'h0, 32'hFFFF_FF80, 32'h0, 32'h8000_0008, 5'd31, 1'b1, 1);
    do_instr(2'b11, 32'h0, 32'h0, 32'hDEAD_BEEF, 32'h8000_000C, 5'd1, 1'b1, 0);
    do_instr(2'b10, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFC, 5'd1, 1'b1, 3);
    read_check("x2_untouched", 5'd2);
    do_instr(2'b00, 32'h1111_1111, 32'h0, 32'h0, 32'h8000_0010, 5'd7, 1'b1, 0);
    do_instr(2'b00, 32'hA5A5_A5A5, 32'h0, 32'h0, 32'h8000_0014, 5'd7, 1'b1, 0);
    do_instr(2'b00, 32'h9999_9999, 32'h0, 32'h0, 32'h8000_0018, 5'd5, 1'b0, 0);
    do_instr(2'b00, 32'hCAFE_F00D, 32'h0, 32'h0, 32'h8000_001C, 5'd20, 1'b1, 0);
    read_check("x5_kept", 5'd5);
    read_check("x31", 5'd31);

    // Asynchronous reset while an rd=3 commit is pending.
    @(negedge clk);
    wbsel = 2'b00; res = 32'h3333_3333; pc = 32'h8000_0020; rd = 5'd3; regwr = 1'b1;
    LSU_valid = 1'b1; IFU_ready = 1'b0;
    @(posedge clk); #1;
    LSU_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", {63'd0, WBU_valid}, 64'd1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_valid", {63'd0, WBU_valid}, 64'd0);
    check("mid_rst_ready", {63'd0, WBU_ready}, 64'd1);
    check("mid_rst_instret", instret, 64'd0);
    check("mid_rst_instret_e", instret_e, 64'd0);
    check("mid_rst_commit_pc", {32'd0, commit_pc}, 64'd0);
    clear_models();
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    read_check("x3_after_rst", 5'd3);
    read_check("x5_after_rst", 5'd5);
    read_check("x31_after_rst", 5'd31);
    @(posedge clk); #1;
    check("post_rst_valid", {63'd0, WBU_valid}, 64'd0);

    do_instr(2'b10, 32'h0, 32'h0, 32'h0, 32'h0000_0100, 5'd3, 1'b1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ysyx_23060221_wbu.md
Name: ysyx_23060221_wbu

Overview:
- Write-back stage directly downstream of the load/store unit; consumes its valid/ready handshake, load data and ALU result.
- Selects the write-back value, commits it to the architectural GPR file (owned here), and signals instruction completion to the IFU.
- Exposes two combinational GPR read ports to the IDU.
- Maintains a retired-instruction counter.

Parameters:
- NR_REGS, 32, number of GPRs (32 for RV32I, 16 for RV32E).
- XLEN, 32, data width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-low (0 = reset asserted).
- LSU_valid  in  1  LSU has a completed instruction.
- WBU_ready  out  1  WBU can accept an instruction.
- lsu_data  in  XLEN  load data, already extended by the LSU.
- res  in  XLEN  ALU result.
- csr_rdata  in  XLEN  CSR old value (csrr*).
- pc  in  XLEN  PC of the instruction.
- rd  in  5  destination register.
- regwr  in  1  instruction writes rd.
- wbsel  in  2  00 res, 01 lsu_data, 10 pc+4, 11 csr_rdata.
- WBU_valid  out  1  commit notification to the IFU.
- IFU_ready  in  1  IFU accepts the commit.
- commit_pc  out  XLEN  PC of the committing instruction.
- rs1_addr, rs2_addr  in  5 each  IDU read addresses.
- rs1_data, rs2_data  out  XLEN each  IDU read data.
- instret  out  64  retired-instruction count.

Behaviour:
- States: IDLE and COMMIT.
  - IDLE: WBU_ready=1, WBU_valid=0.
  - COMMIT: WBU_ready=0, WBU_valid=1.
- Accept: in IDLE, LSU_valid&WBU_ready at an edge captures the following into holding registers (wb_q, rd_q, regwr_q, pc_q) and moves to COMMIT:
  - wb = mux(wbsel), with pc+4 computed modulo 2^32;
  - rd, regwr, pc.
- LSU_valid while in COMMIT is ignored; the LSU must hold its outputs until WBU_ready.
- Latency: accept edge, then WBU_valid=1 from the next cycle.
- COMMIT exit:
  - The GPR write and the instret increment occur at the edge where WBU_valid&IFU_ready.
  - That same edge returns the block to IDLE.
  - While IFU_ready=0, the block stays in COMMIT with outputs stable.
- The commit handshake and a new accept cannot occur in the same edge, because WBU_ready=0 in COMMIT.
- commit_pc = pc_q.
- GPR write rules:
  - Write enabled iff regwr_q and rd_q != 0 and rd_q < NR_REGS.
  - Otherwise no state change.
- GPR read rules:
  - Address 0 returns 0.
  - Address >= NR_REGS returns 0.
  - Otherwise the register value, combinational from the current array state.
- instret: 64-bit, wraps from all-ones to 0; +1 per commit handshake, including instructions that do not write.
- Reset (rst=0, any time, including mid-COMMIT):
  - state=IDLE, WBU_ready=1, WBU_valid=0;
  - commit_pc=0, instret=0, all GPRs=0, holding registers=0.
  - The pending instruction is dropped with no write.
- Release is synchronised by the existing top-level reset synchroniser; no internal synchroniser.

Optional Feature:
- WBU_RD_BYPASS_EN defined:
  - rs1_data/rs2_data forward wb_q when the block is in COMMIT, IFU_ready=1, and the GPR write is enabled with rd_q equal to the read address.
  - The IDU therefore sees the value in the same cycle it is written.
- WBU_RD_BYPASS_EN undefined:
  - Reads return only the array contents.
  - The new value is visible the cycle after the commit edge.

Decomposition:
- Shared package ysyx_23060221_pkg:
  - wbsel encodings WB_ALU=2'b00, WB_MEM=2'b01, WB_PC4=2'b10, WB_CSR=2'b11;
  - state enum wbu_state_t {IDLE, COMMIT};
  - XLEN constant.
- Sub-module ysyx_23060221_gpr holds:
  - the NR_REGS×XLEN array;
  - one write port (wen, waddr, wdata);
  - two combinational read ports with the x0 and out-of-range rules;
  - async active-low clear;
  - the bypass under WBU_RD_BYPASS_EN.
- The WBU top keeps the FSM, mux, holding registers and instret.

Test Plan:
- Basic write-back:
  - Stimulus: reset, then LSU_valid=1, wbsel=00, res=0x1234_5678, rd=5, regwr=1, IFU_ready=1.
  - Response: WBU_valid one cycle later; after commit, rs1_addr=5 reads 0x1234_5678; instret=1.
- Load write-back and x0 write:
  - wbsel=01, lsu_data=0xFFFF_FF80, rd=0, regwr=1: after commit, reading x0 returns 0 and instret=1.
  - Then rd=31 with the same data: x31=0xFFFF_FF80.
- pc+4 wrap with IFU back-pressure:
  - Stimulus: wbsel=10, pc=0xFFFF_FFFC, rd=1; hold IFU_ready=0 for 3 cycles.
  - Response: WBU_valid and commit_pc=0xFFFF_FFFC stable and WBU_ready=0 throughout; LSU_valid pulses are ignored; after IFU_ready=1, x1=0x0000_0000.
- Reset mid-operation:
  - Stimulus: rst=0 asserted asynchronously while in COMMIT with rd=3.
  - Response: immediately WBU_valid=0, WBU_ready=1, instret=0; x3 reads 0 after reset.
- Bypass:
  - With WBU_RD_BYPASS_EN: committing rd=7 with value 0xA5A5_A5A5 while rs2_addr=7 gives rs2_data=0xA5A5_A5A5 in the commit cycle.
  - Without WBU_RD_BYPASS_EN: rs2_data holds the old value until the next cycle.
- RV32E range:
  - Stimulus: NR_REGS=16, write rd=20 with regwr=1.
  - Response: no array change; read of 20 returns 0; instret still increments.
